// File: rtl/stop_watch_lap_mem_if.sv
// Button/display bus between the stopwatch core and its user-facing logic.
// The master side drives buttons and the display range; the slave is the stopwatch.
interface stop_watch_lap_mem_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int IDX_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  logic [2:0]       btn_pedge;
  logic             disp_min;
  logic [15:0]      value;
  logic             running;
  logic             recall;
  logic [IDX_W-1:0] recall_idx;
  logic [CNT_W-1:0] lap_cnt;
  logic             lap_full;

  modport master (
    output btn_pedge, disp_min,
    input  value, running, recall, recall_idx, lap_cnt, lap_full
  );

  modport slave (
    input  btn_pedge, disp_min,
    output value, running, recall, recall_idx, lap_cnt, lap_full
  );
endinterface

// File: rtl/stop_watch_lap_mem.sv
// Multi-lap BCD stopwatch (mm:ss.cc) with lap memory and recall stepping.
// Optional macro STOP_WATCH_LAP_OVERWRITE_EN: laps taken while full overwrite the oldest entry.
//
// state     | meaning
// ST_IDLE   | stopped, live time on the display
// ST_RUN    | counting, live time on the display
// ST_RECALL | stopped, stored lap recall_idx on the display
module stop_watch_lap_mem #(
  parameter int CSEC_DIV  = 1_000_000,
  parameter int LAP_DEPTH = 4,
  parameter int IDX_W     = $clog2(LAP_DEPTH),
  parameter int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
  input logic                 clk,
  input logic                 reset_n,
  stop_watch_lap_mem_if.slave bus
);
  localparam int PRE_W = $clog2(CSEC_DIV);
  localparam int AW    = IDX_W + 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RECALL = 2'd2;

  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_pre;
  logic [23:0]      r_time;
  logic [23:0]      r_lap_mem [LAP_DEPTH];
  logic [IDX_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_lap_cnt;
  logic [IDX_W-1:0] r_recall_idx;

  logic             w_clr, w_ss, w_lap;
  logic             w_full;
  logic             w_tick;
  logic [23:0]      w_time_inc;
  logic [IDX_W-1:0] w_wr_next;
  logic [AW-1:0]    w_rd_sum;
  logic [IDX_W-1:0] w_rd_addr;
  logic [23:0]      w_src;

  assign w_clr  = bus.btn_pedge[0];
  assign w_ss   = bus.btn_pedge[1];
  assign w_lap  = bus.btn_pedge[2];
  assign w_full = (r_lap_cnt == CNT_W'(LAP_DEPTH));
  assign w_tick = (r_pre == PRE_W'(CSEC_DIV - 1));

  assign w_wr_next = (r_wr_ptr == IDX_W'(LAP_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;

  // Oldest valid entry sits lap_cnt slots behind the write pointer.
  assign w_rd_sum  = AW'(r_wr_ptr) + AW'(LAP_DEPTH) - AW'(r_lap_cnt) + AW'(r_recall_idx);
  assign w_rd_addr = (w_rd_sum >= AW'(LAP_DEPTH)) ? IDX_W'(w_rd_sum - AW'(LAP_DEPTH))
                                                  : IDX_W'(w_rd_sum);

  always_comb begin
    w_time_inc = r_time;
    if (r_time[3:0] != 4'd9) begin
      w_time_inc[3:0] = r_time[3:0] + 4'd1;
    end else begin
      w_time_inc[3:0] = 4'd0;
      if (r_time[7:4] != 4'd9) begin
        w_time_inc[7:4] = r_time[7:4] + 4'd1;
      end else begin
        w_time_inc[7:4] = 4'd0;
        if (r_time[11:8] != 4'd9) begin
          w_time_inc[11:8] = r_time[11:8] + 4'd1;
        end else begin
          w_time_inc[11:8] = 4'd0;
          if (r_time[15:12] != 4'd5) begin
            w_time_inc[15:12] = r_time[15:12] + 4'd1;
          end else begin
            w_time_inc[15:12] = 4'd0;
            if (r_time[19:16] != 4'd9) begin
              w_time_inc[19:16] = r_time[19:16] + 4'd1;
            end else begin
              w_time_inc[19:16] = 4'd0;
              w_time_inc[23:20] = (r_time[23:20] != 4'd5) ? r_time[23:20] + 4'd1 : 4'd0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pre        <= '0;
      r_time       <= '0;
      r_wr_ptr     <= '0;
      r_lap_cnt    <= '0;
      r_recall_idx <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_tick) begin
            r_pre  <= '0;
            r_time <= w_time_inc;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
          if (w_lap) begin
            if (!w_full) begin
              r_lap_mem[r_wr_ptr] <= r_time;
              r_wr_ptr            <= w_wr_next;
              r_lap_cnt           <= r_lap_cnt + CNT_W'(1);
            end
`ifdef STOP_WATCH_LAP_OVERWRITE_EN
            else begin
              r_lap_mem[r_wr_ptr] <= r_time;
              r_wr_ptr            <= w_wr_next;
            end
`endif
          end
          if (w_ss) r_state <= ST_IDLE;
        end
        ST_IDLE, ST_RECALL: begin
          if (w_clr) begin
            r_state      <= ST_IDLE;
            r_pre        <= '0;
            r_time       <= '0;
            r_wr_ptr     <= '0;
            r_lap_cnt    <= '0;
            r_recall_idx <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
          end else if (w_ss) begin
            r_state      <= ST_RUN;
            r_recall_idx <= '0;
          end else if (w_lap && (r_lap_cnt != '0)) begin
            if (r_state == ST_IDLE) begin
              r_state      <= ST_RECALL;
              r_recall_idx <= '0;
            end else if ((CNT_W'(r_recall_idx) + CNT_W'(1)) < r_lap_cnt) begin
              r_recall_idx <= r_recall_idx + 1'b1;
            end else begin
              r_state      <= ST_IDLE;
              r_recall_idx <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_src = (r_state == ST_RECALL) ? r_lap_mem[w_rd_addr] : r_time;

  assign bus.value      = bus.disp_min ? w_src[23:8] : w_src[15:0];
  assign bus.running    = (r_state == ST_RUN);
  assign bus.recall     = (r_state == ST_RECALL);
  assign bus.recall_idx = r_recall_idx;
  assign bus.lap_cnt    = r_lap_cnt;
  assign bus.lap_full   = w_full;
endmodule

// File: tb/tb_stop_watch_lap_mem.sv
// Directed bench for stop_watch_lap_mem with CSEC_DIV = 4, LAP_DEPTH = 4.
module tb_stop_watch_lap_mem;
  localparam int CSEC_DIV  = 4;
  localparam int LAP_DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [23:0] preload;
  logic [23:0] wrap_pre [4];
  logic [23:0] wrap_nxt [4];
  logic [15:0] rec_exp  [4];

  stop_watch_lap_mem_if #(.LAP_DEPTH(LAP_DEPTH)) bus ();

  stop_watch_lap_mem #(.CSEC_DIV(CSEC_DIV), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [2:0] b);
    bus.btn_pedge = b;
    cyc(1);
    bus.btn_pedge = 3'b000;
  endtask

  initial begin
    wrap_pre[0] = 24'h000099; wrap_nxt[0] = 24'h000100;
    wrap_pre[1] = 24'h005999; wrap_nxt[1] = 24'h010000;
    wrap_pre[2] = 24'h095999; wrap_nxt[2] = 24'h100000;
    wrap_pre[3] = 24'h595999; wrap_nxt[3] = 24'h000000;
`ifdef STOP_WATCH_LAP_OVERWRITE_EN
    rec_exp[0] = 16'h0003; rec_exp[1] = 16'h0005; rec_exp[2] = 16'h0007; rec_exp[3] = 16'h0009;
`else
    rec_exp[0] = 16'h0001; rec_exp[1] = 16'h0003; rec_exp[2] = 16'h0005; rec_exp[3] = 16'h0007;
`endif

    bus.btn_pedge = 3'b000;
    bus.disp_min  = 1'b0;
    reset_n       = 1'b0;
    cyc(3);
    chk("rst_value",   bus.value, 16'h0000);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_recall",  bus.recall, 1'b0);
    chk("rst_lap_cnt", bus.lap_cnt, 3'd0);
    chk("rst_full",    bus.lap_full, 1'b0);
    reset_n = 1'b1;
    cyc(1);

    // first increment lands CSEC_DIV cycles after the start edge
    pulse(3'b010);
    chk("start_running", bus.running, 1'b1);
    chk("start_value",   bus.value, 16'h0000);
    cyc(3);
    chk("pre_first_tick", bus.value, 16'h0000);
    cyc(1);
    chk("first_tick", bus.value, 16'h0001);
    cyc(396);
    chk("tick100", bus.value, 16'h0100);

    // stop with prescaler at 2, resume continues the partial centisecond
    cyc(1);
    pulse(3'b010);
    chk("pause_running", bus.running, 1'b0);
    cyc(25);
    chk("pause_mid", bus.value, 16'h0100);
    cyc(25);
    chk("pause_end", bus.value, 16'h0100);
    pulse(3'b010);
    chk("resume_running", bus.running, 1'b1);
    cyc(1);
    chk("resume_pre", bus.value, 16'h0100);
    cyc(1);
    chk("resume_tick", bus.value, 16'h0101);

    // lap at 01.23 on a tick edge, lap at 02.50, stop at 02.53
    cyc(88);
    cyc(3);
    pulse(3'b100);
    chk("lap1_cnt",  bus.lap_cnt, 3'd1);
    chk("lap1_live", bus.value, 16'h0124);
    cyc(504);
    pulse(3'b100);
    chk("lap2_cnt",  bus.lap_cnt, 3'd2);
    chk("lap2_live", bus.value, 16'h0250);
    cyc(10);
    pulse(3'b010);
    chk("stop_running", bus.running, 1'b0);
    chk("stop_value",   bus.value, 16'h0253);

    pulse(3'b100);
    chk("rec1_recall", bus.recall, 1'b1);
    chk("rec1_idx",    bus.recall_idx, 2'd0);
    chk("rec1_value",  bus.value, 16'h0123);
    bus.disp_min = 1'b1;
    #1;
    chk("rec1_min", bus.value, 16'h0001);
    bus.disp_min = 1'b0;
    pulse(3'b100);
    chk("rec2_idx",   bus.recall_idx, 2'd1);
    chk("rec2_value", bus.value, 16'h0250);
    pulse(3'b100);
    chk("rec3_recall", bus.recall, 1'b0);
    chk("rec3_value",  bus.value, 16'h0253);

    // clear is ignored while running
    pulse(3'b010);
    pulse(3'b001);
    chk("clr_run_running", bus.running, 1'b1);
    chk("clr_run_laps",    bus.lap_cnt, 3'd2);
    chk("clr_run_value",   bus.value, 16'h0253);
    pulse(3'b010);
    // clear wins over start when stopped
    pulse(3'b011);
    chk("clr_stop_running", bus.running, 1'b0);
    chk("clr_stop_value",   bus.value, 16'h0000);
    chk("clr_stop_laps",    bus.lap_cnt, 3'd0);
    chk("clr_stop_recall",  bus.recall, 1'b0);
    bus.disp_min = 1'b1;
    #1;
    chk("clr_stop_min", bus.value, 16'h0000);
    bus.disp_min = 1'b0;

    // five laps at .01 .03 .05 .07 .09
    pulse(3'b010);
    for (int k = 0; k < 5; k++) begin
      cyc(7);
      pulse(3'b100);
      if (k == 3) begin
        chk("full4_cnt",  bus.lap_cnt, 3'd4);
        chk("full4_flag", bus.lap_full, 1'b1);
      end
    end
    chk("full5_cnt",  bus.lap_cnt, 3'd4);
    chk("full5_flag", bus.lap_full, 1'b1);
    chk("full5_live", bus.value, 16'h0010);
    pulse(3'b010);
    for (int k = 0; k < 4; k++) begin
      pulse(3'b100);
      chk("full_rec_idx",   bus.recall_idx, k[1:0]);
      chk("full_rec_value", bus.value, rec_exp[k]);
    end
    pulse(3'b100);
    chk("full_rec_exit", bus.recall, 1'b0);
    chk("full_rec_live", bus.value, 16'h0010);

    // digit carries and the 59:59.99 wrap from preloaded times
    for (int k = 0; k < 4; k++) begin
      pulse(3'b001);
      preload = wrap_pre[k];
      force dut.r_time = preload;
      cyc(1);
      release dut.r_time;
      bus.disp_min = 1'b1;
      #1;
      chk("wrap_pre_min", bus.value, wrap_pre[k][23:8]);
      bus.disp_min = 1'b0;
      #1;
      chk("wrap_pre_sec", bus.value, wrap_pre[k][15:0]);
      pulse(3'b010);
      cyc(3);
      chk("wrap_hold", bus.value, wrap_pre[k][15:0]);
      cyc(1);
      bus.disp_min = 1'b1;
      #1;
      chk("wrap_nxt_min", bus.value, wrap_nxt[k][23:8]);
      bus.disp_min = 1'b0;
      #1;
      chk("wrap_nxt_sec", bus.value, wrap_nxt[k][15:0]);
      chk("wrap_running", bus.running, 1'b1);
      pulse(3'b010);
    end

    // reset beats simultaneous buttons mid-count
    pulse(3'b010);
    cyc(2);
    pulse(3'b100);
    chk("pre_rst_laps", bus.lap_cnt, 3'd1);
    reset_n = 1'b0;
    bus.btn_pedge = 3'b110;
    cyc(1);
    reset_n = 1'b1;
    bus.btn_pedge = 3'b000;
    chk("mid_rst_running", bus.running, 1'b0);
    chk("mid_rst_value",   bus.value, 16'h0000);
    chk("mid_rst_laps",    bus.lap_cnt, 3'd0);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stop_watch_lap_mem.md
Name: stop_watch_lap_mem

Overview:
- Parametrised multi-lap stopwatch with a run-time range select, covering 00:00.00 to 59:59.99.
- Keeps an internal BCD time of min:sec:csec.
- Records up to LAP_DEPTH lap times in a small register memory.
- When stopped, lets the user step through the stored laps on the 4-digit FND value bus, which feeds the existing FND driver.

Parameters:
- CSEC_DIV, 1_000_000, clk cycles per centisecond (100 MHz clock). Minimum 2.
- LAP_DEPTH, 4, number of lap entries. Minimum 2.
- IDX_W, $clog2(LAP_DEPTH), recall index width (derived; do not override).
- CNT_W, $clog2(LAP_DEPTH+1), lap count width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- btn_pedge  in  3  one-cycle button pulses: [0] clear, [1] start/stop, [2] lap/recall.
- disp_min  in  1  display range: 0 = sec:csec, 1 = min:sec.
- value  out  16  BCD digits for the FND, most significant digit first.
- running  out  1  high while counting.
- recall  out  1  high while a stored lap is displayed.
- recall_idx  out  IDX_W  lap entry currently displayed.
- lap_cnt  out  CNT_W  number of valid lap entries.
- lap_full  out  1  lap_cnt == LAP_DEPTH.

Behaviour:
- Reset: reset_n low at a clk posedge clears everything.
  - Time, prescaler, running, recall, recall_idx, lap_cnt, write pointer and all lap entries become 0.
  - value = 16'h0000 and lap_full = 0.
  - Reset has priority over all buttons, including mid-count and mid-recall.
- Time register: 24-bit BCD {m10,m1,s10,s1,c10,c1}.
  - c1 ranges 0-9; c10 ranges 0-9; s ranges 00-59; m ranges 00-59.
  - Each digit carries ripple in the same cycle.
  - 59:59.99 wraps to 00:00.00 and keeps running; laps are unaffected.
- Prescaler:
  - Counts 0..CSEC_DIV-1 only while running and holds its value while stopped, so a resume continues the partial centisecond.
  - On the edge where prescaler == CSEC_DIV-1 and running = 1, the prescaler goes to 0 and the time increments by 1 csec.
  - The first increment after a start therefore lands exactly CSEC_DIV running cycles later.
- Button decisions use the registered state of the current cycle (pre-toggle), with priority clear > start/stop, lap.
  - clear while stopped: time, prescaler, lap memory, lap_cnt, write pointer, recall and recall_idx all go to 0. Any start/lap pulse in the same cycle is ignored.
  - clear while running: ignored.
  - start/stop: toggles running. Starting forces recall = 0 and recall_idx = 0.
  - lap while running: the entry at the write pointer takes the pre-increment time, even if a tick occurs in the same cycle.
    - The write pointer advances modulo LAP_DEPTH and lap_cnt increments.
    - When lap_full = 1, behaviour is set by the optional feature.
    - start/stop plus lap in the same running cycle: the lap is recorded, then the watch stops.
  - lap while stopped (recall stepping):
    - If lap_cnt = 0, the pulse is ignored.
    - If recall = 0, recall goes to 1 and recall_idx = 0 (the oldest entry).
    - If recall = 1 and recall_idx < lap_cnt-1, recall_idx increments.
    - Otherwise recall goes to 0 (back to the live display) and recall_idx = 0.
- Entry ordering: index 0 is always the oldest valid entry. The physical read address is (wr_ptr - lap_cnt + recall_idx) mod LAP_DEPTH.
- value (combinational from registers):
  - The source is the selected lap entry if recall = 1, otherwise the live time.
  - disp_min = 0 gives {s10,s1,c10,c1}; disp_min = 1 gives {m10,m1,s10,s1}.
- lap_full = (lap_cnt == LAP_DEPTH).

Optional Feature:
- Macro: STOP_WATCH_LAP_OVERWRITE_EN.
- Defined: a lap taken while full overwrites the oldest entry.
  - The write pointer advances and lap_cnt stays at LAP_DEPTH.
  - Index 0 then refers to the next-oldest surviving lap.
- Undefined: a lap taken while full is discarded. Memory, pointer and lap_cnt are unchanged; lap_full stays 1.

Test Plan (CSEC_DIV = 4, LAP_DEPTH = 4):
- Reset and first increment: hold reset_n low 3 cycles, then pulse btn[1].
  - value = 0000 until 4 cycles after the start pulse, then 0001.
  - After 100 ticks, value = 0100.
- Pause and resume: stop mid-prescale (prescaler = 2), wait 50 cycles, then start.
  - The next increment arrives 2 cycles after the start edge.
  - value is frozen throughout the pause.
- Wrap and display range: preload time near the end by running to 59:59.99 with disp_min = 1.
  - value = 5959, then on the next tick 0000 with running = 1.
- Lap capture: lap pulses at times 00:01.23 and 00:02.50, then stop.
  - Lap pulses: lap_cnt = 2.
  - After the stop, lap #1: recall = 1, idx 0, value = 0123.
  - Lap #2: idx 1, value = 0250.
  - Lap #3: recall = 0, live value shown.
- Full memory: take 5 laps while running.
  - Without macro: lap_cnt = 4, lap_full = 1, idx 0 = first lap.
  - With macro: idx 0 = second lap and idx 3 = fifth lap.
- Clear rules: btn[0] while running leaves time and laps unchanged.
  - btn[0] together with btn[1] while stopped: all state 0, running stays 0.
